// File: rtl/variance_acc_pkg.sv
// Shared definitions for the streaming variance stage: FSM state encoding
// and the accumulator width helpers used to size sum and sum-of-squares.
package variance_acc_pkg;

   typedef enum logic [1:0] {
      ACCUM  = 2'd0,
      FINISH = 2'd1,
      HOLD   = 2'd2
   } state_e;

   // Width of the running sum: N full-scale samples fit exactly.
   function automatic int sum_w(input int width, input int n_log2);
      return width + n_log2;
   endfunction

   // Width of the running sum of squares: N full-scale squares fit exactly.
   function automatic int sq_w(input int width, input int n_log2);
      return 2 * width + n_log2;
   endfunction

endpackage

// File: rtl/variance_acc.sv
// Streaming population mean/variance over blocks of 2**N_LOG2 unsigned
// fixed-point samples. Results are held until the consumer takes them.
module variance_acc
   import variance_acc_pkg::*;
#(
   parameter int WIDTH  = 8,
   parameter int FBITS  = 0,
   parameter int N_LOG2 = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] data_in,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] mean_out,
   output logic [WIDTH-1:0] var_out
);

   localparam int SUM_W = sum_w(WIDTH, N_LOG2);
   localparam int SQ_W  = sq_w(WIDTH, N_LOG2);
   localparam logic [SQ_W:0] SAT_MAX = (SQ_W + 1)'({WIDTH{1'b1}});

   state_e            state_q, state_d;
   logic [N_LOG2-1:0] cnt_q, cnt_d;
   logic [SUM_W-1:0]  sum_q, sum_d;
   logic [SQ_W-1:0]   sumsq_q, sumsq_d;
   logic              out_valid_q, out_valid_d;
   logic [WIDTH-1:0]  mean_q, mean_d;
   logic [WIDTH-1:0]  var_q, var_d;

   logic [2*WIDTH-1:0] din_ext;
   logic [2*WIDTH-1:0] sq;
   logic [WIDTH-1:0]   mean_calc;
   logic [2*WIDTH-1:0] mean_ext;
   logic [2*WIDTH-1:0] msq_full;
   logic [2*WIDTH-1:0] msq;
   logic [2*WIDTH-1:0] ex2;
   logic [SQ_W:0]      diff;
   logic [WIDTH-1:0]   var_sat;
   logic               accept;

   assign in_ready  = (state_q == ACCUM);
   assign out_valid = out_valid_q;
   assign mean_out  = mean_q;
   assign var_out   = var_q;
   assign accept    = in_valid && (state_q == ACCUM);

   // Sample squarer and FINISH-stage arithmetic; the only multiply on the
   // FINISH path is mean*mean, everything else is shifts and one subtract.
   always_comb begin
      din_ext   = {{WIDTH{1'b0}}, data_in};
      sq        = din_ext * din_ext;
      mean_calc = sum_q[SUM_W-1:N_LOG2];
      mean_ext  = {{WIDTH{1'b0}}, mean_calc};
      msq_full  = mean_ext * mean_ext;
      msq       = msq_full >> FBITS;
      ex2       = sumsq_q[SQ_W-1:N_LOG2] >> FBITS;
      diff      = (SQ_W + 1)'(ex2) - (SQ_W + 1)'(msq);
      if (diff[SQ_W]) begin
         var_sat = '0;
      end else if (diff > SAT_MAX) begin
         var_sat = '1;
      end else begin
         var_sat = diff[WIDTH-1:0];
      end
   end

   // Next-state logic: accumulate a block, compute once, hold until taken.
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      sum_d       = sum_q;
      sumsq_d     = sumsq_q;
      out_valid_d = out_valid_q;
      mean_d      = mean_q;
      var_d       = var_q;
      case (state_q)
         ACCUM: begin
            if (accept) begin
               sum_d   = sum_q + SUM_W'(data_in);
               sumsq_d = sumsq_q + SQ_W'(sq);
               cnt_d   = cnt_q + N_LOG2'(1);
               if (cnt_q == '1) begin
                  state_d = FINISH;
               end
            end
         end
         FINISH: begin
            mean_d      = mean_calc;
            var_d       = var_sat;
            out_valid_d = 1'b1;
            sum_d       = '0;
            sumsq_d     = '0;
            state_d     = HOLD;
         end
         HOLD: begin
            if (out_ready) begin
               out_valid_d = 1'b0;
               state_d     = ACCUM;
            end
         end
         default: begin
            state_d = ACCUM;
         end
      endcase
   end

   // State registers; reset discards any partial block or pending result.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q     <= ACCUM;
         cnt_q       <= '0;
         sum_q       <= '0;
         sumsq_q     <= '0;
         out_valid_q <= 1'b0;
         mean_q      <= '0;
         var_q       <= '0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         sum_q       <= sum_d;
         sumsq_q     <= sumsq_d;
         out_valid_q <= out_valid_d;
         mean_q      <= mean_d;
         var_q       <= var_d;
      end
   end

endmodule

// File: tb/tb_variance_acc.sv
// Bench for variance_acc: directed blocks plus randomized blocks checked
// against a plain-arithmetic mean/variance model. Instance A is integer
// (FBITS=0), instance B has 4 fractional bits; both use blocks of 4.
module tb_variance_acc;

   localparam int WIDTH  = 8;
   localparam int N_LOG2 = 2;

   logic clk = 1'b0;
   logic reset;

   logic             in_valid_a, out_ready_a;
   logic [WIDTH-1:0] data_in_a;
   logic             in_ready_a, out_valid_a;
   logic [WIDTH-1:0] mean_a, var_a;

   logic             in_valid_b, out_ready_b;
   logic [WIDTH-1:0] data_in_b;
   logic             in_ready_b, out_valid_b;
   logic [WIDTH-1:0] mean_b, var_b;

   int tests_run    = 0;
   int tests_failed = 0;

   // Free-running clock, rising edges at 5, 15, 25 ...
   always #5 clk = ~clk;

   variance_acc #(.WIDTH(WIDTH), .FBITS(0), .N_LOG2(N_LOG2)) dut_a (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid_a),
      .in_ready  (in_ready_a),
      .data_in   (data_in_a),
      .out_valid (out_valid_a),
      .out_ready (out_ready_a),
      .mean_out  (mean_a),
      .var_out   (var_a)
   );

   variance_acc #(.WIDTH(WIDTH), .FBITS(4), .N_LOG2(N_LOG2)) dut_b (
      .clk       (clk),
      .reset     (reset),
      .in_valid  (in_valid_b),
      .in_ready  (in_ready_b),
      .data_in   (data_in_b),
      .out_valid (out_valid_b),
      .out_ready (out_ready_b),
      .mean_out  (mean_b),
      .var_out   (var_b)
   );

   task automatic checkOutput(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
      tests_run++;
      assert (observed === expected) else begin
         tests_failed++;
         $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
      end
   endtask

   function automatic logic getInReady(input int inst);
      return (inst == 0) ? in_ready_a : in_ready_b;
   endfunction

   function automatic logic getOutValid(input int inst);
      return (inst == 0) ? out_valid_a : out_valid_b;
   endfunction

   function automatic logic [WIDTH-1:0] getMean(input int inst);
      return (inst == 0) ? mean_a : mean_b;
   endfunction

   function automatic logic [WIDTH-1:0] getVar(input int inst);
      return (inst == 0) ? var_a : var_b;
   endfunction

   task automatic driveIn(input int inst, input logic v, input logic [WIDTH-1:0] d);
      if (inst == 0) begin
         in_valid_a = v;
         data_in_a  = d;
      end else begin
         in_valid_b = v;
         data_in_b  = d;
      end
   endtask

   task automatic setOutReady(input int inst, input logic v);
      if (inst == 0) out_ready_a = v;
      else out_ready_b = v;
   endtask

   // Population mean and variance of a 4-sample block, straight from the
   // definition: floor mean, E[x^2] - mean^2 in the sample's fixed point.
   function automatic void refResult(input int s[4], input int fbits,
                                     output int m, output int v);
      int tot, sqsum, ex2, msq;
      tot   = 0;
      sqsum = 0;
      for (int i = 0; i < 4; i++) begin
         tot   += s[i];
         sqsum += s[i] * s[i];
      end
      m   = tot / 4;
      ex2 = (sqsum / 4) / (1 << fbits);
      msq = (m * m) / (1 << fbits);
      v   = ex2 - msq;
      if (v < 0) v = 0;
      if (v > 255) v = 255;
   endfunction

   // Present one sample at a negedge and wait (bounded) until it is taken.
   task automatic applyStimulus(input int inst, input int sample, input string tag);
      int k;
      k = 0;
      driveIn(inst, 1'b1, WIDTH'(sample));
      while (!getInReady(inst) && k < 50) begin
         @(negedge clk);
         k++;
      end
      if (k >= 50) checkOutput({tag, "_accept_timeout"}, 32'd0, 32'd1);
      else @(negedge clk);
      driveIn(inst, 1'b0, '0);
   endtask

   // Feed one block, then check latency, result, hold behaviour and release.
   task automatic runBlock(input int inst, input int s[4], input int gapMax,
                           input int holdCycles, input int expMean,
                           input int expVar, input string tag);
      setOutReady(inst, holdCycles == 0);
      for (int i = 0; i < 4; i++) begin
         repeat ($urandom_range(gapMax, 0)) @(negedge clk);
         applyStimulus(inst, s[i], tag);
      end
      checkOutput({tag, "_valid_after_accept"}, 32'(getOutValid(inst)), 32'd0);
      @(negedge clk);
      checkOutput({tag, "_valid"}, 32'(getOutValid(inst)), 32'd1);
      checkOutput({tag, "_mean"}, 32'(getMean(inst)), 32'(expMean));
      checkOutput({tag, "_var"}, 32'(getVar(inst)), 32'(expVar));
      checkOutput({tag, "_busy"}, 32'(getInReady(inst)), 32'd0);
      for (int h = 0; h < holdCycles; h++) begin
         driveIn(inst, 1'b1, 8'hAA);
         @(negedge clk);
         checkOutput({tag, "_hold_valid"}, 32'(getOutValid(inst)), 32'd1);
         checkOutput({tag, "_hold_mean"}, 32'(getMean(inst)), 32'(expMean));
         checkOutput({tag, "_hold_var"}, 32'(getVar(inst)), 32'(expVar));
         checkOutput({tag, "_hold_ready"}, 32'(getInReady(inst)), 32'd0);
      end
      if (holdCycles > 0) begin
         driveIn(inst, 1'b0, '0);
         setOutReady(inst, 1'b1);
      end
      @(negedge clk);
      checkOutput({tag, "_valid_drop"}, 32'(getOutValid(inst)), 32'd0);
      checkOutput({tag, "_ready_back"}, 32'(getInReady(inst)), 32'd1);
   endtask

   // Directed scenarios followed by randomized blocks on both instances.
   initial begin
      int s[4];
      int m, v;

      reset       = 1'b0;
      in_valid_a  = 1'b0;
      data_in_a   = '0;
      out_ready_a = 1'b1;
      in_valid_b  = 1'b0;
      data_in_b   = '0;
      out_ready_b = 1'b1;

      repeat (2) @(negedge clk);
      checkOutput("rst_valid", 32'(out_valid_a), 32'd0);
      checkOutput("rst_mean", 32'(mean_a), 32'd0);
      checkOutput("rst_var", 32'(var_a), 32'd0);
      checkOutput("rst_valid_b", 32'(out_valid_b), 32'd0);
      reset = 1'b1;
      @(negedge clk);
      checkOutput("rst_release_ready", 32'(in_ready_a), 32'd1);

      s = '{2, 4, 4, 6};
      runBlock(0, s, 0, 0, 4, 2, "t1");

      s = '{255, 255, 255, 255};
      runBlock(0, s, 0, 0, 255, 0, "t2");

      s = '{0, 0, 255, 255};
      runBlock(0, s, 0, 0, 127, 255, "t3");

      s = '{10, 20, 30, 40};
      runBlock(0, s, 0, 5, 25, 125, "t4");
      s = '{1, 1, 1, 1};
      runBlock(0, s, 0, 0, 1, 0, "t4_next");

      applyStimulus(0, 9, "t5_pre");
      applyStimulus(0, 9, "t5_pre");
      reset = 1'b0;
      #1;
      checkOutput("t5_rst_valid", 32'(out_valid_a), 32'd0);
      @(negedge clk);
      checkOutput("t5_rst_valid2", 32'(out_valid_a), 32'd0);
      reset = 1'b1;
      s = '{3, 3, 5, 5};
      runBlock(0, s, 3, 0, 4, 1, "t5");

      s = '{16, 48, 16, 48};
      runBlock(1, s, 0, 0, 32, 16, "t6");

      for (int r = 0; r < 8; r++) begin
         for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(255, 0));
         refResult(s, 0, m, v);
         runBlock(0, s, 2, int'($urandom_range(3, 0)), m, v, "rand_a");
      end

      for (int r = 0; r < 4; r++) begin
         for (int i = 0; i < 4; i++) s[i] = int'($urandom_range(255, 0));
         refResult(s, 4, m, v);
         runBlock(1, s, 2, int'($urandom_range(2, 0)), m, v, "rand_b");
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
